// File: rtl/morse_symbol_rec.sv
`default_nettype none
// ============================================================================
//  Module      : morse_symbol_rec
//  Description : Times up to DEPTH Morse mark pulses, classifies dot/dash,
//                flags end-of-character and word gap, holds the result until
//                acknowledged. Optional input debounce: MORSE_DEBOUNCE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_symbol_rec #(
    parameter  int WID      = 32,
    parameter  int DEPTH    = 5,
    parameter  int DOT_MAX  = 15,
    parameter  int GAP_MAX  = 30,
    parameter  int WORD_MAX = 70,
    parameter  int DEB      = 4,
    localparam int IDXW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sig_in,
    input  logic              ack,
    output logic              m_end,
    output logic              valid,
    output logic [IDXW:0]     sym_ct,
    output logic [DEPTH-1:0]  sym_bits,
    output logic              ovf,
    output logic              word_gap,
    input  logic [IDXW-1:0]   rd_idx,
    output logic [WID-1:0]    rd_dur
);

    localparam logic [IDXW:0]  DEPTH_C    = (IDXW+1)'(DEPTH);
    localparam logic [WID-1:0] DOT_MAX_C  = WID'(DOT_MAX);
    localparam logic [WID-1:0] GAP_MAX_C  = WID'(GAP_MAX);
    localparam logic [WID-1:0] WORD_MAX_C = WID'(WORD_MAX);
    localparam logic [WID-1:0] ONE_C      = WID'(1);

    generate
        if (DEPTH < 2 || GAP_MAX < 2 || WORD_MAX <= GAP_MAX || DEB < 1) begin : g_param_check
            $error("morse_symbol_rec: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARK  = 2'd1,
        S_SPACE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic sig_r;

`ifdef MORSE_DEBOUNCE_EN
    localparam int            DEBW  = $clog2(DEB + 1);
    localparam logic [DEBW-1:0] DEB_LAST = DEBW'(DEB - 1);

    logic            sync1_q, sync2_q;
    logic            filt_q, filt_d;
    logic [DEBW-1:0] deb_cnt_q, deb_cnt_d;

    // Filter output flips on the DEB-th consecutive cycle at the new level.
    always_comb begin
        filt_d    = filt_q;
        deb_cnt_d = '0;
        if (sync2_q != filt_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                filt_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEBW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            filt_q    <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= sig_in;
            sync2_q   <= sync1_q;
            filt_q    <= filt_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign sig_r = filt_q;
`else
    logic sig_r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_r_q <= 1'b0;
        end else begin
            sig_r_q <= sig_in;
        end
    end

    assign sig_r = sig_r_q;
`endif

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [WID-1:0]      mark_cnt_q, mark_cnt_d;
    logic [WID-1:0]      space_cnt_q, space_cnt_d;
    logic [IDXW:0]       sym_ct_q, sym_ct_d;
    logic [DEPTH-1:0]    sym_bits_q, sym_bits_d;
    logic                ovf_q, ovf_d;
    logic                word_gap_q, word_gap_d;
    logic                wg_run_q, wg_run_d;
    logic                m_end_q, m_end_d;
    logic                valid_q, valid_d;
    logic [WID-1:0]      dur_buf_q [DEPTH];
    logic [WID-1:0]      dur_buf_d [DEPTH];
    logic [WID-1:0]      rd_dur_q, rd_dur_d;
    logic [IDXW-1:0]     wr_idx;

    function automatic logic [WID-1:0] sat_inc(input logic [WID-1:0] v);
        return (v == {WID{1'b1}}) ? v : v + ONE_C;
    endfunction

    assign wr_idx = sym_ct_q[IDXW-1:0];

    always_comb begin
        state_d     = state_q;
        mark_cnt_d  = mark_cnt_q;
        space_cnt_d = space_cnt_q;
        sym_ct_d    = sym_ct_q;
        sym_bits_d  = sym_bits_q;
        ovf_d       = ovf_q;
        word_gap_d  = word_gap_q;
        wg_run_d    = wg_run_q;
        m_end_d     = m_end_q;
        valid_d     = 1'b0;
        dur_buf_d   = dur_buf_q;

        case (state_q)
            S_IDLE: begin
                if (sig_r) begin
                    state_d    = S_MARK;
                    mark_cnt_d = ONE_C;
                end
            end

            S_MARK: begin
                if (sig_r) begin
                    mark_cnt_d = sat_inc(mark_cnt_q);
                end else begin
                    if (sym_ct_q < DEPTH_C) begin
                        dur_buf_d[wr_idx]  = mark_cnt_q;
                        sym_bits_d[wr_idx] = (mark_cnt_q > DOT_MAX_C);
                        sym_ct_d           = sym_ct_q + (IDXW+1)'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    space_cnt_d = ONE_C;
                    state_d     = S_SPACE;
                end
            end

            S_SPACE: begin
                if (sig_r) begin
                    state_d    = S_MARK;
                    mark_cnt_d = ONE_C;
                end else begin
                    space_cnt_d = sat_inc(space_cnt_q);
                    if (space_cnt_d >= GAP_MAX_C) begin
                        state_d  = S_DONE;
                        m_end_d  = 1'b1;
                        valid_d  = 1'b1;
                        wg_run_d = 1'b1;
                    end
                end
            end

            S_DONE: begin
                if (ack) begin
                    state_d     = S_IDLE;
                    sym_ct_d    = '0;
                    sym_bits_d  = '0;
                    ovf_d       = 1'b0;
                    word_gap_d  = 1'b0;
                    wg_run_d    = 1'b0;
                    m_end_d     = 1'b0;
                    mark_cnt_d  = '0;
                    space_cnt_d = '0;
                end else if (wg_run_q) begin
                    // A mark during DONE permanently halts the word-gap timer.
                    if (sig_r) begin
                        wg_run_d = 1'b0;
                    end else begin
                        space_cnt_d = sat_inc(space_cnt_q);
                        if (space_cnt_d >= WORD_MAX_C) begin
                            word_gap_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_dur_d = '0;
        if ({1'b0, rd_idx} < DEPTH_C) begin
            rd_dur_d = dur_buf_q[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mark_cnt_q  <= '0;
            space_cnt_q <= '0;
            sym_ct_q    <= '0;
            sym_bits_q  <= '0;
            ovf_q       <= 1'b0;
            word_gap_q  <= 1'b0;
            wg_run_q    <= 1'b0;
            m_end_q     <= 1'b0;
            valid_q     <= 1'b0;
            dur_buf_q   <= '{default: '0};
            rd_dur_q    <= '0;
        end else begin
            state_q     <= state_d;
            mark_cnt_q  <= mark_cnt_d;
            space_cnt_q <= space_cnt_d;
            sym_ct_q    <= sym_ct_d;
            sym_bits_q  <= sym_bits_d;
            ovf_q       <= ovf_d;
            word_gap_q  <= word_gap_d;
            wg_run_q    <= wg_run_d;
            m_end_q     <= m_end_d;
            valid_q     <= valid_d;
            dur_buf_q   <= dur_buf_d;
            rd_dur_q    <= rd_dur_d;
        end
    end

    assign m_end    = m_end_q;
    assign valid    = valid_q;
    assign sym_ct   = sym_ct_q;
    assign sym_bits = sym_bits_q;
    assign ovf      = ovf_q;
    assign word_gap = word_gap_q;
    assign rd_dur   = rd_dur_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_symbol_rec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morse_symbol_rec
//  Description : Directed and random character stimulus for morse_symbol_rec
//                with a per-character reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_symbol_rec;

    localparam int WID      = 32;
    localparam int DEPTH    = 5;
    localparam int IDXW     = 3;
    localparam int DOT_MAX  = 15;
    localparam int GAP_MAX  = 30;
    localparam int WORD_MAX = 70;

    logic              clk = 1'b0;
    logic              reset;
    logic              sig_in;
    logic              ack;
    logic              m_end;
    logic              valid;
    logic [IDXW:0]     sym_ct;
    logic [DEPTH-1:0]  sym_bits;
    logic              ovf;
    logic              word_gap;
    logic [IDXW-1:0]   rd_idx;
    logic [WID-1:0]    rd_dur;

    int errors = 0;
    int checks = 0;

    int marks[$];
    int spaces[$];

    morse_symbol_rec dut (
        .clk      (clk),
        .reset    (reset),
        .sig_in   (sig_in),
        .ack      (ack),
        .m_end    (m_end),
        .valid    (valid),
        .sym_ct   (sym_ct),
        .sym_bits (sym_bits),
        .ovf      (ovf),
        .word_gap (word_gap),
        .rd_idx   (rd_idx),
        .rd_dur   (rd_dur)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_end"},    32'(m_end),    0);
        chk({tag, "_valid"},    32'(valid),    0);
        chk({tag, "_sym_ct"},   32'(sym_ct),   0);
        chk({tag, "_sym_bits"}, 32'(sym_bits), 0);
        chk({tag, "_ovf"},      32'(ovf),      0);
        chk({tag, "_word_gap"}, 32'(word_gap), 0);
    endtask

    // Wait for m_end after the final mark's falling edge has been driven.
    task automatic wait_mend(output int n);
        n = 0;
        while (m_end !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
    endtask

    // Drives the character held in marks/spaces, checks the character-level
    // result against the model, reads every stored duration back and acks.
    task automatic send_char(input string tag, input bit do_ack, input bit ack_in_space);
        int n;
        int exp_ct;
        logic [DEPTH-1:0] exp_bits;
        n = marks.size();
        exp_ct = (n < DEPTH) ? n : DEPTH;
        exp_bits = '0;
        for (int i = 0; i < exp_ct; i++) exp_bits[i] = (marks[i] > DOT_MAX);

        for (int i = 0; i < n; i++) begin
            sig_in = 1'b1;
            tick();
            if (i > 0) chk({tag, "_no_end_mid"}, 32'(m_end), 0);
            ticks(marks[i] - 1);
            sig_in = 1'b0;
            if (i < n - 1) begin
                if (ack_in_space) ack = 1'b1;
                ticks(spaces[i]);
                ack = 1'b0;
            end
        end
        begin
            int lat;
            wait_mend(lat);
            chk({tag, "_end_lat"}, 32'(lat), 32'(GAP_MAX + 1));
        end
        chk({tag, "_valid_hi"}, 32'(valid),    1);
        chk({tag, "_sym_ct"},   32'(sym_ct),   32'(exp_ct));
        chk({tag, "_sym_bits"}, 32'(sym_bits), 32'(exp_bits));
        chk({tag, "_ovf"},      32'(ovf),      32'(n > DEPTH));
        tick();
        chk({tag, "_valid_lo"}, 32'(valid), 0);
        chk({tag, "_m_end_hold"}, 32'(m_end), 1);
        for (int i = 0; i < exp_ct; i++) begin
            rd_idx = IDXW'(i);
            tick();
            chk({tag, "_rd_dur"}, rd_dur, 32'(marks[i]));
        end
        rd_idx = 3'd5;
        tick();
        chk({tag, "_rd_oob"}, rd_dur, 0);
        rd_idx = 3'd0;
        if (do_ack) begin
            ack = 1'b1;
            tick();
            ack = 1'b0;
            chk_all_zero({tag, "_ack"});
        end
    endtask

    initial begin
        reset  = 1'b1;
        sig_in = 1'b0;
        ack    = 1'b0;
        rd_idx = '0;
        ticks(3);
        chk_all_zero("reset");
        chk("reset_rd_dur", rd_dur, 0);
        reset = 1'b0;
        tick();

        // Mixed dots and dash, ack pulsed during spaces must be ignored.
        marks = '{10, 20, 10};
        spaces = '{5, 5};
        send_char("basic", 1'b1, 1'b1);

        // Dot/dash threshold with a space one short of the character gap.
        marks = '{15, 16};
        spaces = '{GAP_MAX - 1};
        send_char("thresh", 1'b1, 1'b0);

        // Overflow: seven marks, only five kept.
        marks = '{10, 10, 10, 10, 10, 10, 10};
        spaces = '{5, 5, 5, 5, 5, 5};
        send_char("ovf", 1'b1, 1'b0);

        // Word gap boundary.
        marks = '{10};
        spaces = '{};
        send_char("wg", 1'b0, 1'b0);
        // send_char consumed GAP_MAX+1 + 1 + 1 + 1 low ticks so far.
        ticks(WORD_MAX - (GAP_MAX + 4));
        chk("wg_before", 32'(word_gap), 0);
        tick();
        chk("wg_at", 32'(word_gap), 1);
        chk("wg_m_end", 32'(m_end), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_all_zero("wg_ack");

        // Ack before the word gap, then idle low, then recapture.
        marks = '{10};
        send_char("early", 1'b0, 1'b0);
        ticks(50 - (GAP_MAX + 4));
        chk("early_wg", 32'(word_gap), 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_all_zero("early_ack");
        ticks(40);
        chk_all_zero("early_idle");
        marks = '{10};
        send_char("recap", 1'b1, 1'b0);

        // Marks during DONE are ignored and stop the word-gap timer.
        marks = '{12};
        send_char("donemark", 1'b0, 1'b0);
        sig_in = 1'b1;
        ticks(3);
        sig_in = 1'b0;
        ticks(80);
        chk("donemark_wg", 32'(word_gap), 0);
        chk("donemark_ct", 32'(sym_ct), 1);
        chk("donemark_bits", 32'(sym_bits), 0);
        chk("donemark_m_end", 32'(m_end), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // Reset in the middle of a mark.
        sig_in = 1'b1;
        ticks(6);
        reset = 1'b1;
        sig_in = 1'b0;
        tick();
        chk_all_zero("rst_mid");
        reset = 1'b0;
        ticks(40);
        chk_all_zero("rst_mid_after");
        rd_idx = 3'd0;
        tick();
        chk("rst_mid_buf", rd_dur, 0);

        // Reset and ack together in DONE.
        marks = '{20};
        send_char("rstack", 1'b0, 1'b0);
        reset = 1'b1;
        ack = 1'b1;
        tick();
        reset = 1'b0;
        ack = 1'b0;
        chk_all_zero("rstack");
        tick();
        chk("rstack_buf", rd_dur, 0);

        // Short glitch.
`ifdef MORSE_DEBOUNCE_EN
        sig_in = 1'b1;
        ticks(2);
        sig_in = 1'b0;
        ticks(50);
        chk_all_zero("glitch_deb");
`else
        marks = '{2};
        send_char("glitch", 1'b1, 1'b0);
`endif

        // Random characters.
        for (int c = 0; c < 8; c++) begin
            int n;
            n = $urandom_range(1, 7);
            marks.delete();
            spaces.delete();
            for (int i = 0; i < n; i++) marks.push_back($urandom_range(1, 40));
            for (int i = 0; i < n - 1; i++) spaces.push_back($urandom_range(1, GAP_MAX - 1));
            send_char("rand", 1'b1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
